// File: rtl/reg_operand_fetch_pkg.sv
// rtl/reg_operand_fetch_pkg.sv - shared types for the register operand fetch stage
package reg_operand_fetch_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ID_W_DEF = 5;
  localparam int VEC_W_DEF    = 256;
  localparam int OPC_W_DEF    = 8;

  typedef logic [REG_ID_W_DEF-1:0] RegisterID;
  typedef logic [VEC_W_DEF-1:0]    VectorValue;
  typedef logic [OPC_W_DEF-1:0]    opcode_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_t;

  // Decoded instruction as delivered by the decoder, at default widths
  typedef struct packed {
    opcode_t   opcode;
    RegisterID src0_id;
    RegisterID src1_id;
    RegisterID dst_id;
    logic      src0_used;
    logic      src1_used;
    logic      dst_used;
  } decoded_instr_t;

endpackage

// File: rtl/rof_wait_timer.sv
// rtl/rof_wait_timer.sv - consecutive WAIT-cycle counter with sticky expiry flag
module rof_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive WAIT cycles, saturating at the limit, cleared when WAIT is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!in_wait) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flag raises on the edge that completes the TIMEOUT_CYCLES-th WAIT cycle and stays up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired <= 1'b0;
    end else if (in_wait && cnt == LAST) begin
      expired <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// rtl/reg_operand_fetch.sv - operand fetch stage (optional OPERAND_FETCH_TIMEOUT_EN deadlock timer)
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_ID_W       = 5,
  parameter int VEC_W          = 256,
  parameter int OPC_W          = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [OPC_W-1:0]    dec_opcode,
  input  logic [REG_ID_W-1:0] dec_src0_id,
  input  logic [REG_ID_W-1:0] dec_src1_id,
  input  logic [REG_ID_W-1:0] dec_dst_id,
  input  logic                dec_src0_used,
  input  logic                dec_src1_used,
  input  logic                dec_dst_used,
  output logic [REG_ID_W-1:0] rf_rd0_id,
  output logic [REG_ID_W-1:0] rf_rd1_id,
  input  logic [VEC_W-1:0]    rf_rd0_data,
  input  logic [VEC_W-1:0]    rf_rd1_data,
  input  logic                rf_rd0_ok,
  input  logic                rf_rd1_ok,
  output logic                rf_inv_en,
  output logic [REG_ID_W-1:0] rf_inv_id,
  input  logic                rf_halted,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OPC_W-1:0]    ex_opcode,
  output logic [VEC_W-1:0]    ex_op0,
  output logic [VEC_W-1:0]    ex_op1,
  output logic [REG_ID_W-1:0] ex_dst_id,
  output logic                ex_dst_used,
  output logic                err_timeout,
  output logic                err_bad_id
);

  // One extra bit so NUM_REGS == 2**REG_ID_W still compares correctly
  localparam logic [REG_ID_W:0] NUM_REGS_L = (REG_ID_W + 1)'(NUM_REGS);

  fetch_state_t state;

  logic [OPC_W-1:0]    h_opcode;
  logic [REG_ID_W-1:0] h_src0_id, h_src1_id, h_dst_id;
  logic                h_src0_used, h_src1_used, h_dst_used;

  logic s0_in, s1_in, d_in;
  logic s0_use, s1_use, d_use;
  logic bad_id;
  logic accept, srcs_ready, capture, issue_done;

  assign s0_in  = ({1'b0, dec_src0_id} < NUM_REGS_L);
  assign s1_in  = ({1'b0, dec_src1_id} < NUM_REGS_L);
  assign d_in   = ({1'b0, dec_dst_id}  < NUM_REGS_L);
  // Out-of-range fields are dropped to "unused" so the instruction can still issue
  assign s0_use = dec_src0_used && s0_in;
  assign s1_use = dec_src1_used && s1_in;
  assign d_use  = dec_dst_used  && d_in;
  assign bad_id = (dec_src0_used && !s0_in) || (dec_src1_used && !s1_in) ||
                  (dec_dst_used && !d_in);

  assign dec_ready  = rst_n && (state == FS_IDLE) && !rf_halted;
  assign accept     = dec_valid && dec_ready;
  assign srcs_ready = (!h_src0_used || rf_rd0_ok) && (!h_src1_used || rf_rd1_ok);
  assign capture    = (state == FS_WAIT) && srcs_ready;
  assign issue_done = (state == FS_ISSUE) && ex_ready;
  assign ex_valid   = (state == FS_ISSUE);

  // Register-file addresses and the invalidate are only presented in WAIT
  assign rf_rd0_id = (state == FS_WAIT) ? h_src0_id : '0;
  assign rf_rd1_id = (state == FS_WAIT) ? h_src1_id : '0;
  assign rf_inv_en = capture && h_dst_used;
  assign rf_inv_id = rf_inv_en ? h_dst_id : '0;

  // Main sequencing: IDLE -> WAIT -> ISSUE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_IDLE;
    end else begin
      case (state)
        FS_IDLE:  if (accept)     state <= FS_WAIT;
        FS_WAIT:  if (srcs_ready) state <= FS_ISSUE;
        FS_ISSUE: if (ex_ready)   state <= FS_IDLE;
        default:                  state <= FS_IDLE;
      endcase
    end
  end

  // Hold register for the accepted instruction; unused IDs are zeroed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_opcode    <= '0;
      h_src0_id   <= '0;
      h_src1_id   <= '0;
      h_dst_id    <= '0;
      h_src0_used <= 1'b0;
      h_src1_used <= 1'b0;
      h_dst_used  <= 1'b0;
    end else if (accept) begin
      h_opcode    <= dec_opcode;
      h_src0_id   <= s0_use ? dec_src0_id : '0;
      h_src1_id   <= s1_use ? dec_src1_id : '0;
      h_dst_id    <= d_use  ? dec_dst_id  : '0;
      h_src0_used <= s0_use;
      h_src1_used <= s1_use;
      h_dst_used  <= d_use;
    end else if (issue_done) begin
      h_opcode    <= '0;
      h_src0_id   <= '0;
      h_src1_id   <= '0;
      h_dst_id    <= '0;
      h_src0_used <= 1'b0;
      h_src1_used <= 1'b0;
      h_dst_used  <= 1'b0;
    end
  end

  // Issue register: operands captured in the same cycle the invalidate goes out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_opcode   <= '0;
      ex_op0      <= '0;
      ex_op1      <= '0;
      ex_dst_id   <= '0;
      ex_dst_used <= 1'b0;
    end else if (capture) begin
      ex_opcode   <= h_opcode;
      ex_op0      <= h_src0_used ? rf_rd0_data : '0;
      ex_op1      <= h_src1_used ? rf_rd1_data : '0;
      ex_dst_id   <= h_dst_id;
      ex_dst_used <= h_dst_used;
    end else if (issue_done) begin
      ex_opcode   <= '0;
      ex_op0      <= '0;
      ex_op1      <= '0;
      ex_dst_id   <= '0;
      ex_dst_used <= 1'b0;
    end
  end

  // Sticky flag for any used register ID outside the architectural range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bad_id <= 1'b0;
    end else if (accept && bad_id) begin
      err_bad_id <= 1'b1;
    end
  end

`ifdef OPERAND_FETCH_TIMEOUT_EN
  rof_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_wait (state == FS_WAIT),
    .expired (err_timeout)
  );
`else
  // Parameter kept so both builds share one interface
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_operand_fetch.sv
// tb/tb_reg_operand_fetch.sv - directed self-checking bench for reg_operand_fetch
module tb_reg_operand_fetch;

  localparam int NR = 32;
  localparam int IW = 6;
  localparam int VW = 32;
  localparam int OW = 8;
  localparam int TO = 15;

`ifdef OPERAND_FETCH_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_valid, dec_ready;
  logic [OW-1:0] dec_opcode;
  logic [IW-1:0] dec_src0_id, dec_src1_id, dec_dst_id;
  logic          dec_src0_used, dec_src1_used, dec_dst_used;
  logic [IW-1:0] rf_rd0_id, rf_rd1_id;
  logic [VW-1:0] rf_rd0_data, rf_rd1_data;
  logic          rf_rd0_ok, rf_rd1_ok;
  logic          rf_inv_en;
  logic [IW-1:0] rf_inv_id;
  logic          rf_halted;
  logic          ex_valid, ex_ready;
  logic [OW-1:0] ex_opcode;
  logic [VW-1:0] ex_op0, ex_op1;
  logic [IW-1:0] ex_dst_id;
  logic          ex_dst_used;
  logic          err_timeout, err_bad_id;

  logic [VW-1:0] regs [64];
  logic          okv  [64];

  int n_checks = 0;
  int n_fail   = 0;
  int inv_pulses = 0;
  int inv_base;

  always #5 clk = ~clk;

  reg_operand_fetch #(
    .NUM_REGS(NR), .REG_ID_W(IW), .VEC_W(VW), .OPC_W(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_src0_id(dec_src0_id), .dec_src1_id(dec_src1_id), .dec_dst_id(dec_dst_id),
    .dec_src0_used(dec_src0_used), .dec_src1_used(dec_src1_used), .dec_dst_used(dec_dst_used),
    .rf_rd0_id(rf_rd0_id), .rf_rd1_id(rf_rd1_id),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .rf_rd0_ok(rf_rd0_ok), .rf_rd1_ok(rf_rd1_ok),
    .rf_inv_en(rf_inv_en), .rf_inv_id(rf_inv_id), .rf_halted(rf_halted),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_dst_id(ex_dst_id), .ex_dst_used(ex_dst_used),
    .err_timeout(err_timeout), .err_bad_id(err_bad_id)
  );

  // Register file model: combinational read of value and valid bit
  always_comb begin
    rf_rd0_data = regs[rf_rd0_id];
    rf_rd1_data = regs[rf_rd1_id];
    rf_rd0_ok   = okv[rf_rd0_id];
    rf_rd1_ok   = okv[rf_rd1_id];
  end

  // Count invalidate pulses mid-cycle
  always @(negedge clk) if (rf_inv_en) inv_pulses++;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present one instruction for a single cycle; it must be accepted
  task automatic send(input logic [OW-1:0] op,
                      input logic [IW-1:0] s0, input logic s0u,
                      input logic [IW-1:0] s1, input logic s1u,
                      input logic [IW-1:0] d,  input logic du);
    dec_valid = 1'b1; dec_opcode = op;
    dec_src0_id = s0; dec_src0_used = s0u;
    dec_src1_id = s1; dec_src1_used = s1u;
    dec_dst_id  = d;  dec_dst_used  = du;
    settle();
    expect_eq("accept_ready", 64'(dec_ready), 64'd1);
    tick();
    dec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      regs[i] = VW'(32'hA000 + i);
      okv[i]  = 1'b1;
    end
    regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd9;
    rst_n = 1'b0; dec_valid = 1'b1; dec_opcode = '0;
    dec_src0_id = '0; dec_src1_id = '0; dec_dst_id = '0;
    dec_src0_used = 1'b0; dec_src1_used = 1'b0; dec_dst_used = 1'b0;
    rf_halted = 1'b0; ex_ready = 1'b1;

    // Reset state
    tick(); tick();
    expect_eq("rst_dec_ready", 64'(dec_ready), 64'd0);
    expect_eq("rst_ex_valid", 64'(ex_valid), 64'd0);
    expect_eq("rst_inv_en", 64'(rf_inv_en), 64'd0);
    expect_eq("rst_rd0_id", 64'(rf_rd0_id), 64'd0);
    expect_eq("rst_ex_op0", 64'(ex_op0), 64'd0);
    expect_eq("rst_err_bad", 64'(err_bad_id), 64'd0);
    expect_eq("rst_err_to", 64'(err_timeout), 64'd0);
    dec_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_eq("idle_ready", 64'(dec_ready), 64'd1);

    // Basic issue: r3 = op(r1=5, r2=7), minimum latency
    inv_base = inv_pulses;
    send(8'h10, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1);
    settle();
    expect_eq("b_wait_ex_valid", 64'(ex_valid), 64'd0);
    expect_eq("b_wait_ready", 64'(dec_ready), 64'd0);
    expect_eq("b_rd0_id", 64'(rf_rd0_id), 64'd1);
    expect_eq("b_rd1_id", 64'(rf_rd1_id), 64'd2);
    expect_eq("b_inv_en", 64'(rf_inv_en), 64'd1);
    expect_eq("b_inv_id", 64'(rf_inv_id), 64'd3);
    tick();
    expect_eq("b_ex_valid_n2", 64'(ex_valid), 64'd1);
    expect_eq("b_opcode", 64'(ex_opcode), 64'h10);
    expect_eq("b_op0", 64'(ex_op0), 64'd5);
    expect_eq("b_op1", 64'(ex_op1), 64'd7);
    expect_eq("b_dst_id", 64'(ex_dst_id), 64'd3);
    expect_eq("b_dst_used", 64'(ex_dst_used), 64'd1);
    expect_eq("b_issue_inv_en", 64'(rf_inv_en), 64'd0);
    expect_eq("b_issue_rd0_id", 64'(rf_rd0_id), 64'd0);
    tick();
    expect_eq("b_done_ex_valid", 64'(ex_valid), 64'd0);
    expect_eq("b_done_ready", 64'(dec_ready), 64'd1);
    expect_eq("b_inv_pulses", 64'(inv_pulses - inv_base), 64'd1);

    // Stall: r1 not valid for 4 WAIT cycles, operand taken from the ok cycle
    okv[1] = 1'b0; regs[1] = 32'h11;
    inv_base = inv_pulses;
    send(8'h21, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      settle();
      expect_eq("s_wait_inv_en", 64'(rf_inv_en), 64'd0);
      expect_eq("s_wait_ex_valid", 64'(ex_valid), 64'd0);
      tick();
    end
    okv[1] = 1'b1; regs[1] = 32'h55;
    settle();
    expect_eq("s_ok_inv_en", 64'(rf_inv_en), 64'd1);
    expect_eq("s_ok_inv_id", 64'(rf_inv_id), 64'd4);
    tick();
    expect_eq("s_ex_valid", 64'(ex_valid), 64'd1);
    expect_eq("s_op0", 64'(ex_op0), 64'h55);
    expect_eq("s_op1", 64'(ex_op1), 64'd7);
    tick();
    expect_eq("s_inv_pulses", 64'(inv_pulses - inv_base), 64'd1);

    // Back-pressure: ex_ready low for 3 ISSUE cycles, unused src1 reads as 0
    ex_ready = 1'b0;
    send(8'h33, 6'd2, 1'b1, 6'd9, 1'b0, 6'd5, 1'b1);
    tick();
    dec_valid = 1'b1; dec_opcode = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      settle();
      expect_eq("bp_ex_valid", 64'(ex_valid), 64'd1);
      expect_eq("bp_opcode", 64'(ex_opcode), 64'h33);
      expect_eq("bp_op0", 64'(ex_op0), 64'd7);
      expect_eq("bp_op1", 64'(ex_op1), 64'd0);
      expect_eq("bp_dec_ready", 64'(dec_ready), 64'd0);
      tick();
    end
    dec_valid = 1'b0; ex_ready = 1'b1;
    settle();
    expect_eq("bp_4th_valid", 64'(ex_valid), 64'd1);
    tick();
    expect_eq("bp_done", 64'(ex_valid), 64'd0);

    // src0 == dst: read and invalidate in the same cycle
    send(8'h40, 6'd3, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1);
    settle();
    expect_eq("sd_rd0_id", 64'(rf_rd0_id), 64'd3);
    expect_eq("sd_inv_en", 64'(rf_inv_en), 64'd1);
    expect_eq("sd_inv_id", 64'(rf_inv_id), 64'd3);
    tick();
    expect_eq("sd_op0", 64'(ex_op0), 64'd9);
    expect_eq("sd_op1", 64'(ex_op1), 64'd0);
    tick();

    // src0 == src1
    send(8'h41, 6'd2, 1'b1, 6'd2, 1'b1, 6'd7, 1'b0);
    settle();
    expect_eq("ss_inv_en", 64'(rf_inv_en), 64'd0);
    tick();
    expect_eq("ss_op0", 64'(ex_op0), 64'd7);
    expect_eq("ss_op1", 64'(ex_op1), 64'd7);
    tick();

    // Out-of-range destination: flagged, not invalidated, still issued
    inv_base = inv_pulses;
    send(8'h50, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40, 1'b1);
    settle();
    expect_eq("bad_err", 64'(err_bad_id), 64'd1);
    expect_eq("bad_inv_en", 64'(rf_inv_en), 64'd0);
    tick();
    expect_eq("bad_ex_valid", 64'(ex_valid), 64'd1);
    expect_eq("bad_dst_used", 64'(ex_dst_used), 64'd0);
    expect_eq("bad_op0", 64'(ex_op0), 64'h55);
    tick();
    expect_eq("bad_inv_pulses", 64'(inv_pulses - inv_base), 64'd0);

    // Halt while busy: in-flight completes, nothing new accepted
    send(8'h60, 6'd2, 1'b1, 6'd0, 1'b0, 6'd8, 1'b1);
    rf_halted = 1'b1;
    tick();
    expect_eq("h_ex_valid", 64'(ex_valid), 64'd1);
    expect_eq("h_op0", 64'(ex_op0), 64'd7);
    dec_valid = 1'b1;
    tick();
    settle();
    expect_eq("h_dec_ready", 64'(dec_ready), 64'd0);
    tick();
    expect_eq("h_no_accept_rd", 64'(rf_rd0_id), 64'd0);
    expect_eq("h_bad_sticky", 64'(err_bad_id), 64'd1);
    dec_valid = 1'b0; rf_halted = 1'b0;
    settle();
    expect_eq("h_resume_ready", 64'(dec_ready), 64'd1);

    // Deadlock: r6 never valid, then reset mid-WAIT
    okv[6] = 1'b0;
    inv_base = inv_pulses;
    send(8'h70, 6'd6, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      settle();
      expect_eq("to_before", 64'(err_timeout), 64'd0);
      expect_eq("to_inv_en", 64'(rf_inv_en), 64'd0);
      tick();
    end
    settle();
    expect_eq("to_after", 64'(err_timeout), 64'(EXP_TO));
    expect_eq("to_still_wait", 64'(rf_rd0_id), 64'd6);
    expect_eq("to_no_issue", 64'(ex_valid), 64'd0);
    rst_n = 1'b0;
    okv[6] = 1'b1;
    settle();
    expect_eq("mr_dec_ready", 64'(dec_ready), 64'd0);
    expect_eq("mr_err_to", 64'(err_timeout), 64'd0);
    expect_eq("mr_err_bad", 64'(err_bad_id), 64'd0);
    expect_eq("mr_rd0_id", 64'(rf_rd0_id), 64'd0);
    expect_eq("mr_inv_en", 64'(rf_inv_en), 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    expect_eq("mr_ex_valid", 64'(ex_valid), 64'd0);
    expect_eq("mr_idle_ready", 64'(dec_ready), 64'd1);
    expect_eq("mr_inv_pulses", 64'(inv_pulses - inv_base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_operand_fetch.md
REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers (equals MAX_REG_ID).
REQ-002 SHALL have parameter REG_ID_W, default 5, register-ID width; REQ: 2**REG_ID_W >= NUM_REGS.
REQ-003 SHALL have parameter VEC_W, default 256, VectorValue width.
REQ-004 SHALL have parameter OPC_W, default 8, opcode width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1023, WAIT-state deadlock limit.
REQ-006 Ports, exactly; one clock, reset asynchronous active-low:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 dec_valid/dec_ready  in/out  1/1  decoded-instruction handshake
 dec_opcode  in  OPC_W  opcode
 dec_src0_id, dec_src1_id, dec_dst_id  in  REG_ID_W each  register IDs
 dec_src0_used, dec_src1_used, dec_dst_used  in  1 each  field-valid flags
 rf_rd0_id, rf_rd1_id  out  REG_ID_W each  register-file read addresses
 rf_rd0_data, rf_rd1_data  in  VEC_W each  register values (combinational get)
 rf_rd0_ok, rf_rd1_ok  in  1 each  scoreboard is_valid for rd0/rd1
 rf_inv_en/rf_inv_id  out  1/REG_ID_W  mark_invalid request
 rf_halted  in  1  hasHalted
 ex_valid/ex_ready  out/in  1/1  execute handshake
 ex_opcode, ex_op0, ex_op1  out  OPC_W, VEC_W, VEC_W  issued operation
 ex_dst_id/ex_dst_used  out  REG_ID_W/1  destination
 err_timeout  out  1  sticky deadlock flag
 err_bad_id  out  1  sticky out-of-range ID flag

Function
REQ-007 SHALL implement FSM IDLE, WAIT, ISSUE; dec_ready=1 only in IDLE with rf_halted=0.
REQ-008 IDLE: on dec_valid&&dec_ready, SHALL latch all dec_* fields into a hold register, go to WAIT next cycle.
REQ-009 WAIT: rf_rd0_id/rf_rd1_id SHALL be driven from held src IDs; an unused source counts as ready.
REQ-010 WAIT: when every used source's rf_rdN_ok=1 in the same cycle, SHALL capture ex_op0/ex_op1 (unused operand = 0), pulse rf_inv_en for one cycle with rf_inv_id=held dst if dst_used, go to ISSUE.
REQ-011 Minimum latency: accept at cycle N -> ex_valid=1 at N+2; while any used source not ok, SHALL stay in WAIT with no rf_inv_en.
REQ-012 ISSUE: ex_valid=1, ex_* stable until ex_valid&&ex_ready, then IDLE next cycle; max throughput one instruction per 3 cycles.
REQ-013 src==dst (e.g. r3=r3+1): operand read and invalidate SHALL occur in the same WAIT cycle; captured value is the pre-invalidate value.
REQ-014 src0==src1 SHALL be legal; both operands carry the same value.
REQ-015 Any used ID >= NUM_REGS at accept: SHALL set err_bad_id (sticky), treat that field as unused, still issue.
REQ-016 rf_halted rising while busy: in-flight instruction SHALL complete; no new accept while rf_halted=1.
REQ-017 rf_rd*_id SHALL be 0 and rf_inv_en SHALL be 0 outside WAIT.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, dec_ready=0 while in reset, ex_valid=0, rf_inv_en=0, all ex_*/rf_* outputs 0, err flags 0, hold register cleared.
REQ-019 Reset mid-operation SHALL drop the held instruction; no invalidate is issued for it.

Configuration
REQ-020 With OPERAND_FETCH_TIMEOUT_EN defined: counter counts consecutive WAIT cycles, cleared on leaving WAIT; reaching TIMEOUT_CYCLES SHALL set err_timeout (sticky until reset), FSM continues waiting.
REQ-021 Without OPERAND_FETCH_TIMEOUT_EN: no counter, err_timeout tied 0.

Structure
REQ-022 Shared package SHALL hold RegisterID, VectorValue, opcode type, fetch_state_t enum, decoded_instr_t packed struct.
REQ-023 Timeout counter SHALL be sub-module rof_wait_timer, instantiated only under OPERAND_FETCH_TIMEOUT_EN.

Verification
REQ-024 r1=5,r2=7 both ok, op=0x10 dst=r3, ex_ready=1 -> ex_valid at N+2, op0=5, op1=7, rf_inv_id=3 pulsed once.
REQ-025 r1 not ok for 4 cycles then ok -> WAIT 5 cycles, no rf_inv_en before, ex_op0 = value at ok cycle.
REQ-026 ex_ready=0 for 3 cycles in ISSUE -> ex_* stable, dec_ready=0 throughout; completes on 4th.
REQ-027 src0=dst=r3 (value 9) -> ex_op0=9, rf_inv_id=3 same cycle as capture.
REQ-028 Used dst_id=40 with NUM_REGS=32 -> err_bad_id=1, no rf_inv_en, instruction issued.
REQ-029 With OPERAND_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, source never ok -> err_timeout=1 after 15 WAIT cycles; rst_n pulse mid-WAIT -> IDLE, flags 0.
